hs_dpath_pipe_ctrl: RTL and testbench

Flow-control sequencer for a fixed-latency clock-enable pipeline built from `hs_dpath_sfr_ce_sclr` stages.
- Converts an upstream valid/ready stream and a downstream valid/ready stream into the pipeline's `ce` and `sclr` controls.
- Tracks which stages hold valid data and reports occupancy.
- Provides drain (stop input, empty pipeline) and flush (discard contents) sequencing.
- Sits beside the datapath; carries no payload itself.

---
 rtl/hs_dpath_pipe_ctrl_pkg.sv | 17 +
 rtl/hs_dpath_pipe_ctrl_if.sv | 32 +++
 rtl/hs_dpath_sfr_ce_sclr.sv | 42 ++++
 rtl/hs_dpath_pipe_ctrl.sv | 108 ++++++++++
 tb/tb_hs_dpath_pipe_ctrl.sv | 121 ++++++++++++
 5 files changed

// File: rtl/hs_dpath_pipe_ctrl_pkg.sv
// Shared types for the clock-enable pipeline flow-control sequencer.
// Holds the controller state encoding and the occupancy width helper.
package hs_dpath_pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2,
      FLUSH = 2'd3
   } state_e;

   // Occupancy must be able to represent 0..latency inclusive.
   function automatic int cnt_width(input int latency);
      return $clog2(latency + 1);
   endfunction

endpackage

// File: rtl/hs_dpath_pipe_ctrl_if.sv
// Handshake, pipeline-control and status bundle for hs_dpath_pipe_ctrl.
// The master side is the controller; the slave side is the surrounding system.
interface hs_dpath_pipe_ctrl_if #(
   parameter int LATENCY = 4
);
   import hs_dpath_pipe_ctrl_pkg::*;

   localparam int CNT_W = cnt_width(LATENCY);

   logic             s_valid;
   logic             s_ready;
   logic             m_valid;
   logic             m_ready;
   logic             flush;
   logic             drain_req;
   logic             pipe_ce;
   logic             pipe_sclr;
   logic [CNT_W-1:0] occupancy;
   logic             halted;
   logic             flush_done;

   modport master (
      input  s_valid, m_ready, flush, drain_req,
      output s_ready, m_valid, pipe_ce, pipe_sclr, occupancy, halted, flush_done
   );

   modport slave (
      output s_valid, m_ready, flush, drain_req,
      input  s_ready, m_valid, pipe_ce, pipe_sclr, occupancy, halted, flush_done
   );

endinterface

// File: rtl/hs_dpath_sfr_ce_sclr.sv
// Fixed-latency shift register with clock enable and synchronous clear.
// Clear wins over enable so a flush empties the chain even while it is frozen.
module hs_dpath_sfr_ce_sclr #(
   parameter type      DATA_TYPE   = logic,
   parameter DATA_TYPE RESET_VALUE = DATA_TYPE'(0),
   parameter int       LATENCY     = 4
) (
   input  logic     clk,
   input  logic     aresetn,
   input  logic     ce,
   input  logic     sclr,
   input  DATA_TYPE din,
   output DATA_TYPE dout
);

   genvar gi;
   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_stage
         DATA_TYPE d;
         DATA_TYPE q_reg;

         if (gi == 0) begin : g_head
            assign d = din;
         end else begin : g_link
            assign d = g_stage[gi-1].q_reg;
         end

         always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
               q_reg <= RESET_VALUE;
            end else if (sclr) begin
               q_reg <= RESET_VALUE;
            end else if (ce) begin
               q_reg <= d;
            end
         end
      end
   endgenerate

   assign dout = g_stage[LATENCY-1].q_reg;

endmodule

// File: rtl/hs_dpath_pipe_ctrl.sv
// Flow-control sequencer for a clock-enable pipeline: derives ce/sclr from the
// two handshakes, tracks occupancy and sequences drain and flush.
module hs_dpath_pipe_ctrl
   import hs_dpath_pipe_ctrl_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic                 clk,
   input  logic                 areset,
   hs_dpath_pipe_ctrl_if.master bus
);

   localparam int CNT_W = cnt_width(LATENCY);

   state_e           state_reg, state_next;
   logic [CNT_W-1:0] occ_reg, occ_next;
   logic             vld_last;
   logic             aresetn;
   logic             pipe_ce, pipe_sclr, s_ready, m_valid;
   logic             accept, emit;

   assign aresetn = !areset;

   // Combinational controls are held low while reset is asserted so the
   // datapath never sees an enable before the first clean cycle.
   always_comb begin
      pipe_sclr = !areset && (state_reg == FLUSH);
      pipe_ce   = !areset && (state_reg != FLUSH) && !(vld_last && !bus.m_ready);
      s_ready   = (state_reg == RUN) && pipe_ce && !bus.flush;
      m_valid   = vld_last && (state_reg != FLUSH);
      accept    = bus.s_valid && s_ready;
      emit      = m_valid && bus.m_ready;
   end

   hs_dpath_sfr_ce_sclr #(
      .DATA_TYPE   (logic),
      .RESET_VALUE (1'b0),
      .LATENCY     (LATENCY)
   ) u_vld_chain (
      .clk     (clk),
      .aresetn (aresetn),
      .ce      (pipe_ce),
      .sclr    (pipe_sclr),
      .din     (accept),
      .dout    (vld_last)
   );

   always_comb begin
      occ_next = occ_reg;
      if (state_reg == FLUSH) begin
         occ_next = '0;
      end else if (accept && !emit) begin
         occ_next = occ_reg + CNT_W'(1);
      end else if (emit && !accept) begin
         occ_next = occ_reg - CNT_W'(1);
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         RUN: begin
            if (bus.flush)          state_next = FLUSH;
            else if (bus.drain_req) state_next = DRAIN;
         end
         DRAIN: begin
            // Input is blocked here, so an emit is the only way occupancy moves.
            if (bus.flush)                                     state_next = FLUSH;
            else if (bus.drain_req && occ_reg == CNT_W'(emit)) state_next = HALT;
            else if (!bus.drain_req)                           state_next = RUN;
         end
         HALT: begin
            if (bus.flush)          state_next = FLUSH;
            else if (!bus.drain_req) state_next = RUN;
         end
         FLUSH: begin
            if (bus.flush)          state_next = FLUSH;
            else if (bus.drain_req) state_next = HALT;
            else                    state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_reg <= RUN;
         occ_reg   <= '0;
      end else begin
         state_reg <= state_next;
         occ_reg   <= occ_next;
      end
   end

   assign bus.s_ready    = s_ready;
   assign bus.m_valid    = m_valid;
   assign bus.pipe_ce    = pipe_ce;
   assign bus.pipe_sclr  = pipe_sclr;
   assign bus.occupancy  = occ_reg;
   assign bus.halted     = (state_reg == HALT);
   assign bus.flush_done = (state_reg == FLUSH);

   a_occ_max: assert property (@(posedge clk) disable iff (areset)
      occ_reg <= CNT_W'(LATENCY));
   a_occ_underflow: assert property (@(posedge clk) disable iff (areset)
      !(emit && !accept && occ_reg == '0));

endmodule

// File: tb/tb_hs_dpath_pipe_ctrl.sv
// Directed bench for hs_dpath_pipe_ctrl at LATENCY=4: per-cycle input masks
// with hand-derived expected outputs for each scenario.
module tb_hs_dpath_pipe_ctrl;

   localparam int LATENCY = 4;

   logic clk;
   logic areset;
   int   n_checks;
   int   n_fail;

   hs_dpath_pipe_ctrl_if #(.LATENCY(LATENCY)) dut_if ();

   hs_dpath_pipe_ctrl #(.LATENCY(LATENCY)) dut (
      .clk    (clk),
      .areset (areset),
      .bus    (dut_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Each bit c of a mask is the value for cycle c; occ_v holds one nibble per cycle.
   task automatic run_vec(input string name, input int ncyc,
                          input logic [15:0] sv_m, input logic [15:0] mr_m,
                          input logic [15:0] fl_m, input logic [15:0] dr_m,
                          input logic [15:0] ar_m,
                          input logic [15:0] sr_m, input logic [15:0] mv_m,
                          input logic [15:0] ce_m, input logic [15:0] sclr_m,
                          input logic [15:0] halt_m, input logic [15:0] fd_m,
                          input logic [63:0] occ_v);
      for (int c = 0; c < ncyc; c++) begin
         dut_if.s_valid   = sv_m[c];
         dut_if.m_ready   = mr_m[c];
         dut_if.flush     = fl_m[c];
         dut_if.drain_req = dr_m[c];
         areset           = ar_m[c];
         @(negedge clk);
         chk_eq($sformatf("%s c%0d s_ready", name, c),    int'(dut_if.s_ready),    int'(sr_m[c]));
         chk_eq($sformatf("%s c%0d m_valid", name, c),    int'(dut_if.m_valid),    int'(mv_m[c]));
         chk_eq($sformatf("%s c%0d pipe_ce", name, c),    int'(dut_if.pipe_ce),    int'(ce_m[c]));
         chk_eq($sformatf("%s c%0d pipe_sclr", name, c),  int'(dut_if.pipe_sclr),  int'(sclr_m[c]));
         chk_eq($sformatf("%s c%0d halted", name, c),     int'(dut_if.halted),     int'(halt_m[c]));
         chk_eq($sformatf("%s c%0d flush_done", name, c), int'(dut_if.flush_done), int'(fd_m[c]));
         chk_eq($sformatf("%s c%0d occupancy", name, c),  int'(dut_if.occupancy),  int'(occ_v[c*4 +: 4]));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_checks         = 0;
      n_fail           = 0;
      areset           = 1'b1;
      dut_if.s_valid   = 1'b0;
      dut_if.m_ready   = 1'b0;
      dut_if.flush     = 1'b0;
      dut_if.drain_req = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk_eq("reset s_ready",    int'(dut_if.s_ready),    0);
      chk_eq("reset m_valid",    int'(dut_if.m_valid),    0);
      chk_eq("reset pipe_ce",    int'(dut_if.pipe_ce),    0);
      chk_eq("reset pipe_sclr",  int'(dut_if.pipe_sclr),  0);
      chk_eq("reset occupancy",  int'(dut_if.occupancy),  0);
      chk_eq("reset halted",     int'(dut_if.halted),     0);
      chk_eq("reset flush_done", int'(dut_if.flush_done), 0);
      @(posedge clk);
      #1;

      // 8 back-to-back accepts, m_ready=1: m_valid cycles 4..11, occupancy peaks at 4.
      run_vec("stream", 14,
              16'h00FF, 16'h3FFF, 16'h0000, 16'h0000, 16'h0000,
              16'h3FFF, 16'h0FF0, 16'h3FFF, 16'h0000, 16'h0000, 16'h0000,
              64'h00123444443210);

      // Fill 4, stall 5 cycles, then 4 consecutive emits.
      run_vec("stall", 14,
              16'h000F, 16'h3E00, 16'h0000, 16'h0000, 16'h0000,
              16'h3E0F, 16'h1FF0, 16'h3E0F, 16'h0000, 16'h0000, 16'h0000,
              64'h01234444443210);

      // 3 in flight, drain from cycle 3; s_valid held during drain must not be taken.
      run_vec("drain", 11,
              16'h01F7, 16'h07FF, 16'h0000, 16'h01F8, 16'h0000,
              16'h040F, 16'h0070, 16'h07FF, 16'h0000, 16'h0380, 16'h0000,
              64'h00001233210);

      // 2 in flight, flush together with s_valid in cycle 2.
      run_vec("flush", 7,
              16'h0007, 16'h007F, 16'h0004, 16'h0000, 16'h0000,
              16'h0073, 16'h0000, 16'h0077, 16'h0008, 16'h0000, 16'h0008,
              64'h0002210);

      // flush+drain_req -> FLUSH -> HALT; then back-to-back flush re-enters FLUSH.
      run_vec("flushdrain", 8,
              16'h0000, 16'h00FF, 16'h0031, 16'h0003, 16'h0000,
              16'h0088, 16'h0000, 16'h009D, 16'h0062, 16'h0004, 16'h0062,
              64'h00000000);

      // Reset pulsed in cycle 3 with 3 in flight: data lost, no flush_done.
      run_vec("areset", 8,
              16'h0007, 16'h00FF, 16'h0000, 16'h0000, 16'h0008,
              16'h00F7, 16'h0000, 16'h00F7, 16'h0000, 16'h0000, 16'h0000,
              64'h00000210);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
